apb_master: RTL and testbench
=============================

Name: apb_master

Overview:
- Back half of the AHB-to-APB bridge, directly downstream of the AHB slave front half.
- Pops accepted AHB beats from the control FIFO and, for writes, pops the matching word from the write-data FIFO.
- Runs one APB3/APB4 transfer (SETUP then ACCESS) per beat and pushes read data into the read-data FIFO, which the AHB side pops to drive HRDATA.

Parameters:
- haddrWidth, 8, address width (PADDR width equals HADDR width).
- hdataWidth, 32, data width; fixed at 32 in this revision (PSTRB is 4 bits).
- CTRL_W, 1+2+3+3+haddrWidth, control FIFO entry width, packed {HWRITE, HTRANS, HBURST, HSIZE, HADDR}.

Ports:
- HCLK  in  1  single bridge clock.
- HRESET  in  1  asynchronous, active-high reset.
- ctrl_empty  in  1  control FIFO empty.
- ctrl_rdata  in  CTRL_W  control FIFO head; first-word-fall-through, valid while !ctrl_empty.
- ctrl_ren  out  1  pop control FIFO at this edge.
- ahb_data_empty  in  1  write-data FIFO empty.
- ahb_data_rdata  in  hdataWidth  write-data FIFO head (FWFT).
- ahb_data_ren  out  1  pop write-data FIFO.
- apb_data_full  in  1  read-data FIFO full.
- apb_data_wen  out  1  push read-data FIFO.
- apb_data_wdata  out  hdataWidth  read data payload.
- PSEL  out  1  APB select.
- PENABLE  out  1  APB access phase.
- PWRITE  out  1  APB direction.
- PADDR  out  haddrWidth  APB address.
- PWDATA  out  hdataWidth  APB write data.
- PSTRB  out  4  APB4 byte strobes.
- PRDATA  in  hdataWidth  APB read data.
- PREADY  in  1  APB completer ready.
- PSLVERR  in  1  APB completer error.
- slverr_pulse  out  1  one-cycle flag: completed transfer returned PSLVERR.

Behaviour:
- HRESET asserted: state=IDLE; all outputs 0, including PADDR, PWDATA, PSTRB and apb_data_wdata registers. Takes effect asynchronously mid-transfer: PSEL/PENABLE drop immediately; popped-but-unfinished beats are discarded.
- States: IDLE, WDATA_WAIT, SETUP, ACCESS, RPUSH_WAIT.
- IDLE:
  - if !ctrl_empty, ctrl_ren=1 (combinational, same cycle).
  - Register PWRITE, PADDR=HADDR field, and size/addr[1:0] for strobes.
  - Next state: SETUP for reads; WDATA_WAIT for writes.
- WDATA_WAIT:
  - if !ahb_data_empty, ahb_data_ren=1, register PWDATA, go to SETUP.
  - Otherwise hold; no timeout.
- SETUP: PSEL=1, PENABLE=0; unconditional move to ACCESS.
- ACCESS: PSEL=1, PENABLE=1; hold while !PREADY. On PREADY=1:
  - slverr_pulse = PSLVERR (registered, high the following cycle only).
  - Write: go to IDLE.
  - Read, !apb_data_full: apb_data_wen=1, apb_data_wdata=PRDATA this cycle, go to IDLE.
  - Read, apb_data_full: capture PRDATA into hold register, go to RPUSH_WAIT.
- RPUSH_WAIT: PSEL=0; when !apb_data_full, apb_data_wen=1 with held data, go to IDLE.
- Read data on PSLVERR is still pushed, so FIFO beat count stays aligned; the error is reported only via slverr_pulse.
- PSEL/PENABLE are pure state decodes. PADDR, PWRITE, PWDATA and PSTRB are registered and stable from SETUP through the end of ACCESS.
- PSTRB:
  - Reads: 4'b0000.
  - Writes: HSIZE=byte gives 4'b0001<<addr[1:0]; HSIZE=half gives 4'b0011<<{addr[1],1'b0}; word or larger gives 4'b1111.
- HTRANS and HBURST fields are ignored: each FIFO entry is one beat, and bursts are serialised as independent APB transfers.
- Latency from !ctrl_empty to first PSEL: 1 cycle for reads; for writes, 1 cycle after the write word is available.
- Minimum per-beat occupancy is 3 cycles (IDLE, SETUP, ACCESS), so there is one idle cycle between back-to-back transfers.
- ctrl_ren, ahb_data_ren and apb_data_wen never assert while their FIFO is empty/full, and each is at most a single-cycle pulse per beat.

Decomposition:
- Shared package bridge_pkg holds:
  - HTRANS/HBURST/HSIZE encodings.
  - Packed ctrl-entry struct, shared with the AHB slave.
  - apb_state_t enum.
  - strobe-generation function.
- No sub-module needed; a single always_ff/always_comb FSM plus datapath registers.

Test Plan:
- Read, addr 0x10, PREADY=1 immediately, PRDATA=0xDEADBEEF -> PSEL high 2 cycles, PWRITE=0, PSTRB=0, apb_data_wen pulses once with 0xDEADBEEF.
- Write word, addr 0x24; data 0xA5A5A5A5 arrives 3 cycles after ctrl -> FSM holds WDATA_WAIT 3 cycles, then SETUP; PWDATA=0xA5A5A5A5, PSTRB=4'hF.
- Byte write, addr 0x03; then half write, addr 0x06 -> PSTRB=4'b1000, then 4'b1100; PADDR stable through ACCESS.
- Read with PREADY low 4 cycles and apb_data_full high 2 cycles after completion -> PENABLE high 5 cycles; data held in RPUSH_WAIT; single push after full drops.
- Write completes with PSLVERR=1 -> slverr_pulse high exactly one cycle; next queued beat proceeds normally.
- HRESET asserted mid-ACCESS -> PSEL/PENABLE 0 immediately; after release, FSM in IDLE and resumes from next ctrl entry.

Source files
------------

// File: rtl/bridge_pkg.sv
// Shared AHB-to-APB bridge types: AHB encodings, ctrl FIFO entry,
// APB-side FSM states and the APB4 strobe helper.
package bridge_pkg;

  localparam int HADDR_W = 8;
  localparam int HDATA_W = 32;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_t;

  typedef enum logic [2:0] {
    HBURST_SINGLE = 3'b000,
    HBURST_INCR   = 3'b001,
    HBURST_WRAP4  = 3'b010,
    HBURST_INCR4  = 3'b011,
    HBURST_WRAP8  = 3'b100,
    HBURST_INCR8  = 3'b101,
    HBURST_WRAP16 = 3'b110,
    HBURST_INCR16 = 3'b111
  } hburst_t;

  typedef enum logic [2:0] {
    HSIZE_BYTE  = 3'b000,
    HSIZE_HALF  = 3'b001,
    HSIZE_WORD  = 3'b010,
    HSIZE_DWORD = 3'b011,
    HSIZE_4W    = 3'b100,
    HSIZE_8W    = 3'b101,
    HSIZE_16W   = 3'b110,
    HSIZE_32W   = 3'b111
  } hsize_t;

  typedef struct packed {
    logic                hwrite;
    htrans_t             htrans;
    hburst_t             hburst;
    hsize_t              hsize;
    logic [HADDR_W-1:0]  haddr;
  } ctrl_entry_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WDATA_WAIT,
    ST_SETUP,
    ST_ACCESS,
    ST_RPUSH_WAIT
  } apb_state_t;

  function automatic logic [3:0] pstrb_gen(
    input logic       hwrite,
    input logic [2:0] hsize,
    input logic [1:0] addr
  );
    logic [3:0] s;
    s = 4'b1111;
    if (!hwrite)
      s = 4'b0000;
    else if (hsize == HSIZE_BYTE)
      s = 4'b0001 << addr;
    else if (hsize == HSIZE_HALF)
      s = 4'b0011 << {addr[1], 1'b0};
    return s;
  endfunction

endpackage

// File: rtl/apb_master_if.sv
// APB3/APB4 bus between the bridge master and a completer.
interface apb_master_if #(
  parameter int AW = 8,
  parameter int DW = 32
);
  logic          PSEL;
  logic          PENABLE;
  logic          PWRITE;
  logic [AW-1:0] PADDR;
  logic [DW-1:0] PWDATA;
  logic [3:0]    PSTRB;
  logic [DW-1:0] PRDATA;
  logic          PREADY;
  logic          PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR,
    output PWDATA, PSTRB,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR,
    input  PWDATA, PSTRB,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/apb_master.sv
// APB half of the AHB-to-APB bridge: one APB transfer per ctrl FIFO
// beat, write data from the wdata FIFO, read data into the rdata FIFO.
module apb_master
  import bridge_pkg::*;
#(
  parameter int haddrWidth = 8,
  parameter int hdataWidth = 32,
  localparam int CTRL_W = 1 + 2 + 3 + 3 + haddrWidth
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic                  ctrl_empty,
  input  logic [CTRL_W-1:0]     ctrl_rdata,
  output logic                  ctrl_ren,
  input  logic                  ahb_data_empty,
  input  logic [hdataWidth-1:0] ahb_data_rdata,
  output logic                  ahb_data_ren,
  input  logic                  apb_data_full,
  output logic                  apb_data_wen,
  output logic [hdataWidth-1:0] apb_data_wdata,
  apb_master_if.master          apb,
  output logic                  slverr_pulse
);

  apb_state_t state, state_n;

  logic                  c_write;
  logic [2:0]            c_size;
  logic [haddrWidth-1:0] c_addr;
  logic                  unused_ctrl;

  assign c_write = ctrl_rdata[CTRL_W-1];
  assign c_size  = ctrl_rdata[haddrWidth +: 3];
  assign c_addr  = ctrl_rdata[haddrWidth-1:0];
  // HTRANS/HBURST are ignored: each entry is already a single beat
  assign unused_ctrl = ^ctrl_rdata[haddrWidth+3 +: 5];

  logic                  pwrite_q;
  logic [haddrWidth-1:0] paddr_q;
  logic [hdataWidth-1:0] pwdata_q;
  logic [3:0]            pstrb_q;
  logic [hdataWidth-1:0] rdata_q;
  logic                  slverr_q;

  logic done;
  logic direct;
  logic hold_rd;

  assign done = (state == ST_ACCESS) && apb.PREADY;

  always_comb begin
    state_n      = state;
    ctrl_ren     = 1'b0;
    ahb_data_ren = 1'b0;
    apb_data_wen = 1'b0;
    direct       = 1'b0;
    hold_rd      = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (!ctrl_empty) begin
          ctrl_ren = 1'b1;
          state_n  = c_write ? ST_WDATA_WAIT : ST_SETUP;
        end
      end
      ST_WDATA_WAIT: begin
        if (!ahb_data_empty) begin
          ahb_data_ren = 1'b1;
          state_n      = ST_SETUP;
        end
      end
      ST_SETUP: state_n = ST_ACCESS;
      ST_ACCESS: begin
        if (apb.PREADY) begin
          if (pwrite_q) begin
            state_n = ST_IDLE;
          end else if (!apb_data_full) begin
            apb_data_wen = 1'b1;
            direct       = 1'b1;
            state_n      = ST_IDLE;
          end else begin
            hold_rd = 1'b1;
            state_n = ST_RPUSH_WAIT;
          end
        end
      end
      ST_RPUSH_WAIT: begin
        if (!apb_data_full) begin
          apb_data_wen = 1'b1;
          state_n      = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) state <= ST_IDLE;
    else        state <= state_n;
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      pwrite_q <= 1'b0;
      paddr_q  <= '0;
      pwdata_q <= '0;
      pstrb_q  <= '0;
      rdata_q  <= '0;
      slverr_q <= 1'b0;
    end else begin
      if (ctrl_ren) begin
        pwrite_q <= c_write;
        paddr_q  <= c_addr;
        pstrb_q  <= pstrb_gen(c_write, c_size, c_addr[1:0]);
      end
      if (ahb_data_ren)
        pwdata_q <= ahb_data_rdata;
      if (hold_rd)
        rdata_q <= apb.PRDATA;
      slverr_q <= done && apb.PSLVERR;
    end
  end

  // Read data bypasses the hold register when the FIFO has room
  assign apb_data_wdata = direct ? apb.PRDATA : rdata_q;
  assign slverr_pulse   = slverr_q;

  assign apb.PSEL    = (state == ST_SETUP) || (state == ST_ACCESS);
  assign apb.PENABLE = (state == ST_ACCESS);
  assign apb.PWRITE  = pwrite_q;
  assign apb.PADDR   = paddr_q;
  assign apb.PWDATA  = pwdata_q;
  assign apb.PSTRB   = pstrb_q;

endmodule

// File: tb/tb_apb_master.sv
// Randomized scoreboard bench for apb_master with FIFO and
// APB completer models.
module tb_apb_master;
  import bridge_pkg::*;

  localparam int AW = 8;
  localparam int DW = 32;
  localparam int CW = 1 + 2 + 3 + 3 + AW;

  logic          HCLK = 1'b0;
  logic          HRESET = 1'b1;
  logic          ctrl_empty = 1'b1;
  logic [CW-1:0] ctrl_rdata = '0;
  logic          ctrl_ren;
  logic          ahb_data_empty = 1'b1;
  logic [DW-1:0] ahb_data_rdata = '0;
  logic          ahb_data_ren;
  logic          apb_data_full = 1'b0;
  logic          apb_data_wen;
  logic [DW-1:0] apb_data_wdata;
  logic          slverr_pulse;

  apb_master_if #(.AW(AW), .DW(DW)) apb ();

  apb_master #(
    .haddrWidth(AW),
    .hdataWidth(DW)
  ) dut (
    .HCLK          (HCLK),
    .HRESET        (HRESET),
    .ctrl_empty    (ctrl_empty),
    .ctrl_rdata    (ctrl_rdata),
    .ctrl_ren      (ctrl_ren),
    .ahb_data_empty(ahb_data_empty),
    .ahb_data_rdata(ahb_data_rdata),
    .ahb_data_ren  (ahb_data_ren),
    .apb_data_full (apb_data_full),
    .apb_data_wen  (apb_data_wen),
    .apb_data_wdata(apb_data_wdata),
    .apb           (apb),
    .slverr_pulse  (slverr_pulse)
  );

  always #5 HCLK = ~HCLK;

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [3:0]    strb;
    logic [DW-1:0] wdata;
  } xfer_t;

  typedef struct {
    logic [DW-1:0] data;
    int            ready;
  } wpend_t;

  logic [CW-1:0] ctrl_q[$];
  wpend_t        wd_pend[$];
  logic [DW-1:0] wd_q[$];
  xfer_t         exp_x[$];
  logic [DW-1:0] exp_rd[$];

  int vectors = 0;
  int errors = 0;
  int cyc = 0;
  int last_ready = 0;

  logic force_wait = 1'b0;
  logic saw_access = 1'b0;
  logic exp_slv = 1'b0;
  logic snap_valid = 1'b0;
  logic [AW+DW+4:0] snap;

  task automatic check(input string name, input logic [63:0] got,
                       input logic [63:0] want);
    vectors++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h (t=%0t)", name, got, want,
               $time);
    end
  endtask

  function automatic logic [3:0] ref_strb(input logic wr,
                                          input logic [2:0] sz,
                                          input logic [AW-1:0] a);
    int s;
    if (!wr)          s = 0;
    else if (sz == 0) s = 1 << (a % 4);
    else if (sz == 1) s = 3 << (a & 2);
    else              s = 15;
    return s[3:0];
  endfunction

  task automatic issue(input logic wr, input logic [2:0] sz,
                       input logic [AW-1:0] a, input logic [DW-1:0] wd,
                       input int dly);
    logic [2:0] hb;
    xfer_t x;
    hb = 3'($urandom_range(0, 7));
    ctrl_q.push_back({wr, 2'b10, hb, sz, a});
    if (wr) begin
      last_ready = (cyc + dly > last_ready) ? cyc + dly : last_ready;
      wd_pend.push_back('{wd, last_ready});
    end
    x.wr    = wr;
    x.addr  = a;
    x.strb  = ref_strb(wr, sz, a);
    x.wdata = wd;
    exp_x.push_back(x);
  endtask

  // FIFO + completer environment and monitor
  initial begin
    xfer_t e;
    logic nxt_slv;
    apb.PREADY  = 1'b0;
    apb.PRDATA  = '0;
    apb.PSLVERR = 1'b0;
    forever begin
      @(negedge HCLK);
      cyc++;
      if (HRESET) begin
        snap_valid = 1'b0;
        exp_slv    = 1'b0;
        continue;
      end
      while (wd_pend.size() > 0 && wd_pend[0].ready <= cyc)
        wd_q.push_back(wd_pend.pop_front().data);
      ctrl_empty     = (ctrl_q.size() == 0);
      ctrl_rdata     = ctrl_empty ? '0 : ctrl_q[0];
      ahb_data_empty = (wd_q.size() == 0);
      ahb_data_rdata = ahb_data_empty ? '0 : wd_q[0];
      apb.PREADY     = force_wait ? 1'b0 : ($urandom_range(0, 9) < 6);
      apb.PRDATA     = $urandom;
      apb.PSLVERR    = ($urandom_range(0, 3) == 0);
      apb_data_full  = ($urandom_range(0, 9) < 3);
      #1;
      check("slverr_pulse", 64'(slverr_pulse), 64'(exp_slv));
      nxt_slv = 1'b0;
      if (ctrl_ren) begin
        check("ctrl_ren_empty", 64'(ctrl_empty), 64'(0));
        if (!ctrl_empty) void'(ctrl_q.pop_front());
      end
      if (ahb_data_ren) begin
        check("wd_ren_empty", 64'(ahb_data_empty), 64'(0));
        if (!ahb_data_empty) void'(wd_q.pop_front());
      end
      if (apb.PSEL && exp_rd.size() > 0)
        check("psel_in_rpush", 64'(apb.PSEL), 64'(0));
      if (apb.PSEL && !apb.PENABLE) begin
        snap = {apb.PWRITE, apb.PADDR, apb.PWDATA, apb.PSTRB};
        snap_valid = 1'b1;
      end
      if (apb.PSEL && apb.PENABLE) begin
        saw_access = 1'b1;
        check("access_after_setup", 64'(snap_valid), 64'(1));
        check("bus_stable", 64'({apb.PWRITE, apb.PADDR, apb.PWDATA,
              apb.PSTRB}), 64'(snap));
        if (apb.PREADY) begin
          snap_valid = 1'b0;
          nxt_slv = apb.PSLVERR;
          if (exp_x.size() == 0) begin
            check("unexpected_xfer", 64'(1), 64'(0));
          end else begin
            e = exp_x.pop_front();
            check("pwrite", 64'(apb.PWRITE), 64'(e.wr));
            check("paddr", 64'(apb.PADDR), 64'(e.addr));
            check("pstrb", 64'(apb.PSTRB), 64'(e.strb));
            if (e.wr)
              check("pwdata", 64'(apb.PWDATA), 64'(e.wdata));
            else
              exp_rd.push_back(apb.PRDATA);
          end
        end
      end
      if (apb_data_wen) begin
        check("wen_full", 64'(apb_data_full), 64'(0));
        if (exp_rd.size() == 0)
          check("unexpected_push", 64'(1), 64'(0));
        else
          check("rdata", 64'(apb_data_wdata), 64'(exp_rd.pop_front()));
      end
      exp_slv = nxt_slv;
    end
  end

  task automatic drain(input string name);
    int g = 0;
    while ((ctrl_q.size() + exp_x.size() + exp_rd.size()) != 0
           && g < 5000) begin
      @(negedge HCLK);
      g++;
    end
    check(name, 64'(exp_x.size() + exp_rd.size()), 64'(0));
  endtask

  initial begin
    int g;
    #1;
    check("reset_bus", 64'({apb.PSEL, apb.PENABLE, apb.PWRITE,
          apb.PSTRB, apb.PADDR}), 64'(0));
    check("reset_pwdata", 64'(apb.PWDATA), 64'(0));
    check("reset_rdata", 64'(apb_data_wdata), 64'(0));
    check("reset_strobes", 64'({ctrl_ren, ahb_data_ren, apb_data_wen,
          slverr_pulse}), 64'(0));
    repeat (3) @(posedge HCLK);
    #2 HRESET = 1'b0;

    issue(1'b0, 3'd2, 8'h10, 32'h0, 0);
    issue(1'b1, 3'd2, 8'h24, 32'hA5A5A5A5, 3);
    issue(1'b1, 3'd0, 8'h03, 32'h11223344, 0);
    issue(1'b1, 3'd1, 8'h06, 32'h55667788, 1);
    drain("drain_directed");

    for (int i = 0; i < 150; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge HCLK);
      issue(1'($urandom_range(0, 1)), 3'($urandom_range(0, 3)),
            8'($urandom), $urandom, $urandom_range(0, 4));
      g = 0;
      while (ctrl_q.size() > 4 && g < 2000) begin
        @(negedge HCLK);
        g++;
      end
    end
    drain("drain_random");

    // Reset in the middle of an ACCESS that never completes
    force_wait = 1'b1;
    saw_access = 1'b0;
    issue(1'b0, 3'd2, 8'h40, 32'h0, 0);
    g = 0;
    while (!saw_access && g < 50) begin
      @(negedge HCLK);
      g++;
    end
    check("reach_access", 64'(saw_access), 64'(1));
    @(posedge HCLK);
    #2 HRESET = 1'b1;
    #1;
    check("rst_psel", 64'({apb.PSEL, apb.PENABLE}), 64'(0));
    if (exp_x.size() > 0) void'(exp_x.pop_front());
    force_wait = 1'b0;
    issue(1'b0, 3'd2, 8'h44, 32'h0, 0);
    issue(1'b1, 3'd0, 8'h49, 32'hCAFEF00D, 2);
    @(posedge HCLK);
    #2 HRESET = 1'b0;
    drain("drain_after_reset");

    $display("== %0d vectors applied, %0d miscompares ==", vectors,
             errors);
    $finish;
  end

endmodule
